// File: rtl/safe_softmax_array.sv
// safe_softmax_array: runs a ROWS x COLS online-softmax tile through LANES safe_softmax row engines.
// Numerators are 2^(x-max) with 5 fraction bits; exp_sum is 1s.10i.5f.

module safe_softmax #(
   parameter int D_W = 8,
   parameter int NUM = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic signed [D_W-1:0] i_data [NUM],
   input  logic signed [D_W-1:0] i_x_max,
   input  logic [15:0]           i_exp_sum,
   output logic                  o_vld,
   output logic signed [D_W-1:0] o_data [NUM],
   output logic signed [D_W-1:0] o_x_max,
   output logic [15:0]           o_exp_sum
);
   logic [1:0] ph;
   logic signed [D_W-1:0] d [NUM];
   logic signed [D_W-1:0] x_in, m, m_nxt;
   logic [15:0] s_in, s_nxt;

   function automatic logic [D_W:0] dif(input logic signed [D_W-1:0] a, input logic signed [D_W-1:0] b);
      return {a[D_W-1], a} - {b[D_W-1], b};
   endfunction

   always_comb begin
      m_nxt = i_x_max;
      for (int c = 0; c < NUM; c++) m_nxt = i_data[c] > m_nxt ? i_data[c] : m_nxt;
   end

   // the old sum is rescaled to the new max; a shift of 16 or more flushes it
   always_comb begin
      s_nxt = s_in >> dif(m, x_in);
      for (int c = 0; c < NUM; c++) s_nxt = s_nxt + (16'd32 >> dif(m, d[c]));
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ph        <= '0;
         o_vld     <= 1'b0;
         d         <= '{default: '0};
         x_in      <= '0;
         m         <= '0;
         s_in      <= '0;
         o_data    <= '{default: '0};
         o_x_max   <= '0;
         o_exp_sum <= '0;
      end else if (!start) begin
         ph    <= '0;
         o_vld <= 1'b0;
      end else begin
         ph    <= ph == 2'd2 ? ph : ph + 2'd1;
         o_vld <= ph == 2'd1;
         if (ph == 2'd0) begin
            d    <= i_data;
            x_in <= i_x_max;
            s_in <= i_exp_sum;
            m    <= m_nxt;
         end
         if (ph == 2'd1) begin
            for (int c = 0; c < NUM; c++) o_data[c] <= D_W'(16'd32 >> dif(m, d[c]));
            o_x_max   <= m;
            o_exp_sum <= s_nxt;
         end
      end
endmodule

module safe_softmax_array #(
   parameter int D_W   = 8,
   parameter int ROWS  = 16,
   parameter int COLS  = 16,
   parameter int LANES = 4
) (
   input  logic                  I_CLK,
   input  logic                  I_RST,
   input  logic                  I_START,
   input  logic                  I_INIT,
   input  logic signed [D_W-1:0] I_DATA [ROWS][COLS],
   input  logic signed [D_W-1:0] I_X_MAX [ROWS],
   input  logic [15:0]           I_EXP_SUM [ROWS],
   output logic                  O_BUSY,
   output logic                  O_VLD,
   output logic signed [D_W-1:0] O_DATA [ROWS][COLS],
   output logic signed [D_W-1:0] O_X_MAX [ROWS],
   output logic [15:0]           O_EXP_SUM [ROWS]
);
   localparam int NB = ROWS / LANES;
   localparam int BW = NB > 1 ? $clog2(NB) : 1;
   localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, CAPT, DONE} state_t;
   state_t state;
   logic [BW-1:0] batch;
   logic signed [D_W-1:0] data_q [ROWS][COLS];
   logic signed [D_W-1:0] x_max_q [ROWS];
   logic [15:0] exp_sum_q [ROWS];
   logic [LANES-1:0] lane_vld;
   logic signed [D_W-1:0] lane_data [LANES][COLS];
   logic signed [D_W-1:0] lane_x_max [LANES];
   logic [15:0] lane_exp_sum [LANES];

   if (ROWS % LANES != 0) begin : g_bad_lanes
      $error("safe_softmax_array: ROWS must be a multiple of LANES");
   end

   function automatic logic [RW-1:0] row_of(input logic [BW-1:0] b, input int k);
      return RW'(int'(b) * LANES + k);
   endfunction

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [RW-1:0] row;
      logic signed [D_W-1:0] feed [COLS];
      logic signed [D_W-1:0] od [COLS];
      assign row = row_of(batch, k);
      for (genvar c = 0; c < COLS; c++) begin : g_col
         assign feed[c]         = data_q[row][c];
         assign lane_data[k][c] = od[c];
      end
      safe_softmax #(.D_W(D_W), .NUM(COLS)) u_row (
         .clk       (I_CLK),
         .rst_n     (~I_RST),
         .start     (state == RUN),
         .i_data    (feed),
         .i_x_max   (x_max_q[row]),
         .i_exp_sum (exp_sum_q[row]),
         .o_vld     (lane_vld[k]),
         .o_data    (od),
         .o_x_max   (lane_x_max[k]),
         .o_exp_sum (lane_exp_sum[k])
      );
   end

   // lanes share one latency, so the AND of their valids marks the batch end
   always_ff @(posedge I_CLK or posedge I_RST)
      if (I_RST) begin
         state     <= IDLE;
         batch     <= '0;
         O_BUSY    <= 1'b0;
         O_VLD     <= 1'b0;
         data_q    <= '{default: '0};
         x_max_q   <= '{default: '0};
         exp_sum_q <= '{default: '0};
         O_DATA    <= '{default: '0};
         O_X_MAX   <= '{default: '0};
         O_EXP_SUM <= '{default: '0};
      end else begin
         O_VLD <= 1'b0;
         case (state)
            IDLE: if (I_START) begin
               state  <= RUN;
               batch  <= '0;
               O_BUSY <= 1'b1;
               data_q <= I_DATA;
               for (int r = 0; r < ROWS; r++) begin
                  x_max_q[r]   <= I_INIT ? {1'b1, {(D_W-1){1'b0}}} : I_X_MAX[r];
                  exp_sum_q[r] <= I_INIT ? 16'h0000 : I_EXP_SUM[r];
               end
            end
            RUN: state <= &lane_vld ? CAPT : RUN;
            CAPT: begin
               for (int k = 0; k < LANES; k++) begin
                  for (int c = 0; c < COLS; c++) O_DATA[row_of(batch, k)][c] <= lane_data[k][c];
                  O_X_MAX[row_of(batch, k)]   <= lane_x_max[k];
                  O_EXP_SUM[row_of(batch, k)] <= lane_exp_sum[k];
               end
               state <= batch == BW'(NB - 1) ? DONE : RUN;
               O_VLD <= batch == BW'(NB - 1);
               batch <= batch + BW'(1);
            end
            DONE: begin
               state  <= IDLE;
               O_BUSY <= 1'b0;
            end
         endcase
      end
endmodule

// File: tb/tb_safe_softmax_array.sv
// tb_safe_softmax_array: directed checks of the time-multiplexed softmax tile against hand values and a row model.
module tb_safe_softmax_array;
   localparam int D_W = 8, ROWS = 16, COLS = 16;

   logic clk = 1'b0, rst = 1'b0, start = 1'b0, start2 = 1'b0, init = 1'b0;
   logic signed [D_W-1:0] din [ROWS][COLS];
   logic signed [D_W-1:0] xin [ROWS];
   logic [15:0] sin [ROWS];
   logic busy_a, vld_a, busy_16, vld_16, busy_1, vld_1;
   logic signed [D_W-1:0] od_a [ROWS][COLS], od_16 [ROWS][COLS], od_1 [ROWS][COLS];
   logic signed [D_W-1:0] om_a [ROWS], om_16 [ROWS], om_1 [ROWS];
   logic [15:0] os_a [ROWS], os_16 [ROWS], os_1 [ROWS];
   int ed [ROWS][COLS];
   int em [ROWS];
   int es [ROWS];
   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   safe_softmax_array #(.D_W(D_W), .ROWS(ROWS), .COLS(COLS), .LANES(4)) u_a (
      .I_CLK(clk), .I_RST(rst), .I_START(start), .I_INIT(init), .I_DATA(din), .I_X_MAX(xin),
      .I_EXP_SUM(sin), .O_BUSY(busy_a), .O_VLD(vld_a), .O_DATA(od_a), .O_X_MAX(om_a), .O_EXP_SUM(os_a));
   safe_softmax_array #(.D_W(D_W), .ROWS(ROWS), .COLS(COLS), .LANES(16)) u_16 (
      .I_CLK(clk), .I_RST(rst), .I_START(start2), .I_INIT(init), .I_DATA(din), .I_X_MAX(xin),
      .I_EXP_SUM(sin), .O_BUSY(busy_16), .O_VLD(vld_16), .O_DATA(od_16), .O_X_MAX(om_16), .O_EXP_SUM(os_16));
   safe_softmax_array #(.D_W(D_W), .ROWS(ROWS), .COLS(COLS), .LANES(1)) u_1 (
      .I_CLK(clk), .I_RST(rst), .I_START(start2), .I_INIT(init), .I_DATA(din), .I_X_MAX(xin),
      .I_EXP_SUM(sin), .O_BUSY(busy_1), .O_VLD(vld_1), .O_DATA(od_1), .O_X_MAX(om_1), .O_EXP_SUM(os_1));

   // golden row model: numerator 32>>(max-x), old sum rescaled by the max increase
   task automatic model();
      for (int r = 0; r < ROWS; r++) begin
         int m, pm, s;
         pm = init ? -128 : int'(xin[r]);
         m  = pm;
         for (int c = 0; c < COLS; c++) if (int'(din[r][c]) > m) m = int'(din[r][c]);
         s = init ? 0 : ((m - pm) > 15 ? 0 : int'(sin[r]) >> (m - pm));
         for (int c = 0; c < COLS; c++) begin
            ed[r][c] = (m - int'(din[r][c])) > 5 ? 0 : 32 >> (m - int'(din[r][c]));
            s += ed[r][c];
         end
         em[r] = m;
         es[r] = s;
      end
   endtask

   task automatic accept_and_wait(output int lat);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (vld_a !== 1'b1 && lat < 200);
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      n_chk++;
      if (busy_a !== 1'b0 || vld_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags busy=%b vld=%b expected 0 0", busy_a, vld_a);
      end
      for (int r = 0; r < ROWS; r += 5) begin
         n_chk++;
         if (om_a[r] !== '0 || os_a[r] !== '0 || od_a[r][r] !== '0) begin
            n_fail++;
            $display("FAIL reset_out row %0d x_max=%h sum=%h data=%h expected 0", r, om_a[r], os_a[r], od_a[r][r]);
         end
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_first_tile();
      int lat;
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) din[r][c] = D_W'(c);
      init = 1'b1;
      accept_and_wait(lat);
      n_chk++;
      if (lat !== 17) begin
         n_fail++;
         $display("FAIL t1_latency got %0d expected 17", lat);
      end
      for (int r = 0; r < ROWS; r++) begin
         n_chk++;
         if (om_a[r] !== 8'sd15 || os_a[r] !== 16'd63) begin
            n_fail++;
            $display("FAIL t1_stats row %0d x_max=%0d sum=%0d expected 15 63", r, om_a[r], os_a[r]);
         end
         for (int c = 0; c < COLS; c++) begin
            int e;
            e = c >= 10 ? 32 >> (15 - c) : 0;
            n_chk++;
            if (od_a[r][c] !== D_W'(e)) begin
               n_fail++;
               $display("FAIL t1_data [%0d][%0d] got %0d expected %0d", r, c, od_a[r][c], e);
            end
         end
      end
   endtask

   task automatic test_second_tile();
      int lat;
      for (int r = 0; r < ROWS; r++) begin
         xin[r] = om_a[r];
         sin[r] = os_a[r];
         for (int c = 0; c < COLS; c++) din[r][c] = D_W'(c + 1);
      end
      init = 1'b0;
      accept_and_wait(lat);
      n_chk++;
      if (lat !== 17) begin
         n_fail++;
         $display("FAIL t2_latency got %0d expected 17", lat);
      end
      for (int r = 0; r < ROWS; r++) begin
         n_chk++;
         if ($isunknown(os_a[r]) || os_a[r] < 16'd93 || os_a[r] > 16'd95 || om_a[r] !== 8'sd16) begin
            n_fail++;
            $display("FAIL t2_stats row %0d x_max=%0d sum=%0d expected 16 94+-1", r, om_a[r], os_a[r]);
         end
         for (int c = 0; c < COLS; c++) begin
            int e;
            e = c >= 10 ? 32 >> (15 - c) : 0;
            n_chk++;
            if (od_a[r][c] !== D_W'(e)) begin
               n_fail++;
               $display("FAIL t2_data [%0d][%0d] got %0d expected %0d", r, c, od_a[r][c], e);
            end
         end
      end
   endtask

   task automatic test_busy_ignore();
      int lat, pulses;
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) din[r][c] = D_W'((r + c) % 20 - 5);
      init = 1'b1;
      model();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      lat = 0;
      pulses = 0;
      while (pulses == 0 && lat < 200) begin
         @(negedge clk);
         lat++;
         din[$urandom_range(ROWS - 1)][$urandom_range(COLS - 1)] = D_W'($urandom);
         xin[$urandom_range(ROWS - 1)] = D_W'($urandom);
         sin[$urandom_range(ROWS - 1)] = 16'($urandom);
         init = ~init;
         if (vld_a === 1'b1) begin
            pulses++;
            start = 1'b0;
         end
      end
      start = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (vld_a === 1'b1) pulses++;
      end
      n_chk++;
      if (pulses !== 1 || lat !== 17) begin
         n_fail++;
         $display("FAIL t3_pulses got %0d pulses at %0d expected 1 at 17", pulses, lat);
      end
      for (int r = 0; r < ROWS; r++) begin
         n_chk++;
         if (om_a[r] !== D_W'(em[r]) || os_a[r] !== 16'(es[r])) begin
            n_fail++;
            $display("FAIL t3_stats row %0d x_max=%0d sum=%0d expected %0d %0d", r, om_a[r], os_a[r], em[r], es[r]);
         end
         for (int c = 0; c < COLS; c++) begin
            n_chk++;
            if (od_a[r][c] !== D_W'(ed[r][c])) begin
               n_fail++;
               $display("FAIL t3_data [%0d][%0d] got %0d expected %0d", r, c, od_a[r][c], ed[r][c]);
            end
         end
      end
   endtask

   task automatic test_reset_midrun();
      int lat;
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) din[r][c] = D_W'(r * 3 - c * 5);
      init = 1'b1;
      model();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(negedge clk);
      n_chk++;
      if (busy_a !== 1'b1 || vld_a !== 1'b0 || om_a[0] !== D_W'(em[0]) || om_a[4] !== D_W'(em[4])) begin
         n_fail++;
         $display("FAIL t4_partial busy=%b vld=%b x0=%0d x4=%0d expected 1 0 %0d %0d",
                  busy_a, vld_a, om_a[0], om_a[4], em[0], em[4]);
      end
      rst = 1'b1;
      #1;
      n_chk++;
      if (busy_a !== 1'b0 || vld_a !== 1'b0) begin
         n_fail++;
         $display("FAIL t4_reset_flags busy=%b vld=%b expected 0 0", busy_a, vld_a);
      end
      for (int r = 0; r < ROWS; r++) begin
         n_chk++;
         if (om_a[r] !== '0 || os_a[r] !== '0 || od_a[r][0] !== '0 || od_a[r][COLS-1] !== '0) begin
            n_fail++;
            $display("FAIL t4_reset_out row %0d x_max=%h sum=%h expected 0", r, om_a[r], os_a[r]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      accept_and_wait(lat);
      n_chk++;
      if (lat !== 17) begin
         n_fail++;
         $display("FAIL t4_latency got %0d expected 17", lat);
      end
      for (int r = 0; r < ROWS; r++) begin
         n_chk++;
         if (om_a[r] !== D_W'(em[r]) || os_a[r] !== 16'(es[r])) begin
            n_fail++;
            $display("FAIL t4_stats row %0d x_max=%0d sum=%0d expected %0d %0d", r, om_a[r], os_a[r], em[r], es[r]);
         end
         for (int c = 0; c < COLS; c++) begin
            n_chk++;
            if (od_a[r][c] !== D_W'(ed[r][c])) begin
               n_fail++;
               $display("FAIL t4_data [%0d][%0d] got %0d expected %0d", r, c, od_a[r][c], ed[r][c]);
            end
         end
      end
   endtask

   task automatic test_lanes();
      int n, l16, l1;
      for (int r = 0; r < ROWS; r++) begin
         xin[r] = D_W'($urandom);
         sin[r] = 16'($urandom_range(0, 4000));
         for (int c = 0; c < COLS; c++) din[r][c] = D_W'($urandom);
      end
      init = 1'b0;
      model();
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      n = 0;
      l16 = 0;
      l1 = 0;
      while ((l16 == 0 || l1 == 0) && n < 200) begin
         @(negedge clk);
         n++;
         if (vld_16 === 1'b1 && l16 == 0) l16 = n;
         if (vld_1 === 1'b1 && l1 == 0) l1 = n;
      end
      n_chk++;
      if (l16 !== 5 || l1 !== 65) begin
         n_fail++;
         $display("FAIL t5_latency lanes16=%0d lanes1=%0d expected 5 65", l16, l1);
      end
      for (int r = 0; r < ROWS; r++) begin
         n_chk++;
         if (om_1[r] !== D_W'(em[r]) || os_1[r] !== 16'(es[r]) || om_16[r] !== om_1[r] || os_16[r] !== os_1[r]) begin
            n_fail++;
            $display("FAIL t5_stats row %0d x_max=%0d/%0d sum=%0d/%0d expected %0d %0d",
                     r, om_16[r], om_1[r], os_16[r], os_1[r], em[r], es[r]);
         end
         for (int c = 0; c < COLS; c++) begin
            n_chk++;
            if (od_1[r][c] !== D_W'(ed[r][c]) || od_16[r][c] !== od_1[r][c]) begin
               n_fail++;
               $display("FAIL t5_data [%0d][%0d] got %0d/%0d expected %0d", r, c, od_16[r][c], od_1[r][c], ed[r][c]);
            end
         end
      end
   endtask

   task automatic test_boundary();
      int lat;
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) din[r][c] = r == 7 ? 8'sd127 : -8'sd128;
      init = 1'b1;
      accept_and_wait(lat);
      n_chk++;
      if (lat !== 17 || $isunknown({busy_a, vld_a})) begin
         n_fail++;
         $display("FAIL t6_latency got %0d busy=%b vld=%b expected 17", lat, busy_a, vld_a);
      end
      for (int r = 0; r < ROWS; r++) begin
         n_chk++;
         if (om_a[r] !== (r == 7 ? 8'sd127 : -8'sd128) || os_a[r] !== 16'd512) begin
            n_fail++;
            $display("FAIL t6_stats row %0d x_max=%0d sum=%0d expected %0d 512", r, om_a[r], os_a[r], r == 7 ? 127 : -128);
         end
         for (int c = 0; c < COLS; c++) begin
            n_chk++;
            if (od_a[r][c] !== 8'sd32) begin
               n_fail++;
               $display("FAIL t6_data [%0d][%0d] got %0d expected 32", r, c, od_a[r][c]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) din[r][c] = D_W'(c - r);
      init = 1'b1;
      model();
      accept_and_wait(lat);
      n_chk++;
      if (lat !== 17 || om_a[3] !== D_W'(em[3]) || os_a[3] !== 16'(es[3])) begin
         n_fail++;
         $display("FAIL t7_first lat=%0d x_max=%0d sum=%0d expected 17 %0d %0d", lat, om_a[3], os_a[3], em[3], es[3]);
      end
      for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) din[r][c] = D_W'(2 * r - c);
      model();
      start = 1'b1;
      @(negedge clk);
      n_chk++;
      if (busy_a !== 1'b0 || vld_a !== 1'b0) begin
         n_fail++;
         $display("FAIL t7_idle_gap busy=%b vld=%b expected 0 0", busy_a, vld_a);
      end
      @(posedge clk);
      #1 start = 1'b0;
      n_chk++;
      if (busy_a !== 1'b1) begin
         n_fail++;
         $display("FAIL t7_accept busy=%b expected 1", busy_a);
      end
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (vld_a !== 1'b1 && lat < 200);
      n_chk++;
      if (lat !== 17) begin
         n_fail++;
         $display("FAIL t7_latency got %0d expected 17", lat);
      end
      for (int r = 0; r < ROWS; r++) begin
         n_chk++;
         if (om_a[r] !== D_W'(em[r]) || os_a[r] !== 16'(es[r])) begin
            n_fail++;
            $display("FAIL t7_stats row %0d x_max=%0d sum=%0d expected %0d %0d", r, om_a[r], os_a[r], em[r], es[r]);
         end
         for (int c = 0; c < COLS; c++) begin
            n_chk++;
            if (od_a[r][c] !== D_W'(ed[r][c])) begin
               n_fail++;
               $display("FAIL t7_data [%0d][%0d] got %0d expected %0d", r, c, od_a[r][c], ed[r][c]);
            end
         end
      end
   endtask

   initial begin
      for (int r = 0; r < ROWS; r++) begin
         xin[r] = '0;
         sin[r] = '0;
         for (int c = 0; c < COLS; c++) din[r][c] = '0;
      end
      test_reset();
      test_first_tile();
      test_second_tile();
      test_busy_ignore();
      test_reset_midrun();
      test_lanes();
      test_boundary();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete in time");
      $fatal(1, "watchdog");
   end
endmodule
